vth_level_detector: RTL and testbench

Read-side hard-decision detector for the NVM flash channel model. Takes the 16-bit post-retention threshold-voltage samples produced by `ChannelModel_top2` and slices them against three programmable read thresholds to recover the 2-bit stored level. When the written level is supplied alongside each sample, it also accumulates sample and error counts over a measurement window, giving an on-chip raw error-rate figure.

---
 rtl/flash_chan_pkg.sv | 22 ++
 rtl/vth_slicer.sv | 49 ++++
 rtl/vth_level_detector.sv | 187 ++++++++++++++++++
 tb/tb_vth_level_detector.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/flash_chan_pkg.sv
// Purpose: shared types and helpers for the flash channel read-side blocks.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package flash_chan_pkg;

  localparam int VTH_W = 16;

  typedef logic [1:0] level_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } win_state_t;

  // Gray code of a stored level: 0->00, 1->01, 2->11, 3->10.
  function automatic level_t gray_of(input level_t lvl);
    return {lvl[1], lvl[1] ^ lvl[0]};
  endfunction

endpackage

// File: rtl/vth_slicer.sv
// Purpose: three-threshold comparator bank (stage 1) and level encoder (stage 2).
// Latency: 2 cycles from sample_vth to det_level; s1_level is stage-1 encoded.
// Backpressure: none, accepts a new sample every cycle.
module vth_slicer #(
  parameter int VTH_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [VTH_W-1:0] sample_vth,
  input  logic [VTH_W-1:0] thr0,
  input  logic [VTH_W-1:0] thr1,
  input  logic [VTH_W-1:0] thr2,
  output logic [1:0]       s1_level,
  output logic [1:0]       det_level
);
  import flash_chan_pkg::*;

  logic [2:0] cmp_d, cmp_q;
  level_t     lvl_d, lvl_q;

  // Compare the sample against every threshold; equality counts as above.
  always_comb begin
    cmp_d    = '0;
    cmp_d[0] = (sample_vth >= thr0);
    cmp_d[1] = (sample_vth >= thr1);
    cmp_d[2] = (sample_vth >= thr2);
  end

  // Level is the number of thresholds met, independent of threshold ordering.
  always_comb begin
    lvl_d = level_t'({1'b0, cmp_q[0]}) + level_t'({1'b0, cmp_q[1]})
          + level_t'({1'b0, cmp_q[2]});
  end

  // Stage-1 compare register and stage-2 level register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cmp_q <= '0;
      lvl_q <= '0;
    end else begin
      cmp_q <= cmp_d;
      lvl_q <= lvl_d;
    end
  end

  assign s1_level  = lvl_d;
  assign det_level = lvl_q;

endmodule

// File: rtl/vth_level_detector.sv
// Purpose: hard-decision level detector with windowed sample/error counters.
// Latency: 2 cycles sample to det_*; counters update 1 cycle after their event.
// Backpressure: none; one sample per cycle. Option macro: VTH_DET_GRAY_EN.
module vth_level_detector #(
  parameter int               VTH_W   = 16,
  parameter int               CNT_W   = 32,
  parameter int               WIN_LEN = 327680,
  parameter logic [VTH_W-1:0] T0_DEF  = 16'd1000,
  parameter logic [VTH_W-1:0] T1_DEF  = 16'd2000,
  parameter logic [VTH_W-1:0] T2_DEF  = 16'd3000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sample_valid,
  input  logic [VTH_W-1:0] sample_vth,
  input  logic [1:0]       ref_level,
  input  logic             cfg_we,
  input  logic [1:0]       cfg_sel,
  input  logic [VTH_W-1:0] cfg_data,
  input  logic             win_start,
  output logic             det_valid,
  output logic [1:0]       det_level,
  output logic [1:0]       det_err,
  output logic             win_busy,
  output logic             win_done,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] err_cnt
);
  import flash_chan_pkg::*;

  // Window position counter is sized for WIN_LEN, not CNT_W, so the window
  // still closes correctly when the visible counters saturate early.
  localparam int              WC_W     = $clog2(WIN_LEN + 1);
  localparam logic [WC_W-1:0] WIN_LAST = WC_W'(WIN_LEN - 1);

  logic [VTH_W-1:0] thr_d [3];
  logic [VTH_W-1:0] thr_q [3];

  logic             s1_vld_d, s1_vld_q;
  level_t           s1_ref_d, s1_ref_q;
  logic             s1_cnt_d, s1_cnt_q;
  logic             det_valid_d, det_valid_q;
  logic [1:0]       det_err_d, det_err_q;
  logic             s2_cnt_d, s2_cnt_q;
  logic [CNT_W-1:0] sample_cnt_d, sample_cnt_q;
  logic [CNT_W-1:0] err_cnt_d, err_cnt_q;
  logic [WC_W-1:0]  win_cnt_d, win_cnt_q;
  logic [CNT_W:0]   err_sum;
  level_t           s1_level;
  level_t           err_diff;
  logic             count_acc;
  logic             err_add;

  win_state_t       state_q;
  logic             win_busy_q, win_done_q;

  vth_slicer #(.VTH_W(VTH_W)) u_slicer (
    .clk        (clk),
    .reset      (reset),
    .sample_vth (sample_vth),
    .thr0       (thr_q[0]),
    .thr1       (thr_q[1]),
    .thr2       (thr_q[2]),
    .s1_level   (s1_level),
    .det_level  (det_level)
  );

  // Threshold writes land in the register, so they apply from the next sample on.
  always_comb begin
    thr_d = thr_q;
    if (cfg_we) begin
      case (cfg_sel)
        2'd0:    thr_d[0] = cfg_data;
        2'd1:    thr_d[1] = cfg_data;
        2'd2:    thr_d[2] = cfg_data;
        default: ;
      endcase
    end
  end

  // A sample counts only while RUN is already open; win_start flushes the
  // counted tags so in-flight samples of an aborted window are never added.
  always_comb begin
    count_acc = sample_valid && (state_q == RUN) && !win_start;
    err_add   = s2_cnt_q && det_valid_q && !win_start;
    s1_vld_d  = sample_valid;
    s1_ref_d  = ref_level;
    s1_cnt_d  = count_acc;
    s2_cnt_d  = s1_cnt_q && !win_start;
  end

  // Error weight of the stage-1 result against the delayed written level.
  always_comb begin
    err_diff    = '0;
    det_valid_d = s1_vld_q;
`ifdef VTH_DET_GRAY_EN
    err_diff  = gray_of(s1_level) ^ gray_of(s1_ref_q);
    det_err_d = {1'b0, err_diff[1]} + {1'b0, err_diff[0]};
`else
    det_err_d = {1'b0, (s1_level != s1_ref_q)};
`endif
  end

  // Saturating sample/error counters plus the unsaturated window position.
  always_comb begin
    sample_cnt_d = sample_cnt_q;
    err_cnt_d    = err_cnt_q;
    win_cnt_d    = win_cnt_q;
    err_sum      = {1'b0, err_cnt_q} + (CNT_W + 1)'(det_err_q);
    if (win_start) begin
      sample_cnt_d = '0;
      err_cnt_d    = '0;
      win_cnt_d    = '0;
    end else begin
      if (count_acc) begin
        win_cnt_d = win_cnt_q + WC_W'(1);
        if (sample_cnt_q != '1) sample_cnt_d = sample_cnt_q + CNT_W'(1);
      end
      if (err_add) err_cnt_d = err_sum[CNT_W] ? '1 : err_sum[CNT_W-1:0];
    end
  end

  // Pipeline, threshold and counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      thr_q[0]     <= T0_DEF;
      thr_q[1]     <= T1_DEF;
      thr_q[2]     <= T2_DEF;
      s1_vld_q     <= 1'b0;
      s1_ref_q     <= '0;
      s1_cnt_q     <= 1'b0;
      det_valid_q  <= 1'b0;
      det_err_q    <= '0;
      s2_cnt_q     <= 1'b0;
      sample_cnt_q <= '0;
      err_cnt_q    <= '0;
      win_cnt_q    <= '0;
    end else begin
      thr_q        <= thr_d;
      s1_vld_q     <= s1_vld_d;
      s1_ref_q     <= s1_ref_d;
      s1_cnt_q     <= s1_cnt_d;
      det_valid_q  <= det_valid_d;
      det_err_q    <= det_err_d;
      s2_cnt_q     <= s2_cnt_d;
      sample_cnt_q <= sample_cnt_d;
      err_cnt_q    <= err_cnt_d;
      win_cnt_q    <= win_cnt_d;
    end
  end

  // Window FSM. DRAIN leaves once stage 1 holds no counted sample: the last
  // one is then in stage 2 and reaches err_cnt on the same edge DONE is entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      win_busy_q <= 1'b0;
      win_done_q <= 1'b0;
    end else if (win_start) begin
      state_q    <= RUN;
      win_busy_q <= 1'b1;
      win_done_q <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (count_acc && (win_cnt_q == WIN_LAST)) state_q <= DRAIN;
        end
        DRAIN: begin
          if (!s1_cnt_q) begin
            state_q    <= DONE;
            win_busy_q <= 1'b0;
            win_done_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign det_valid  = det_valid_q;
  assign det_err    = det_err_q;
  assign win_busy   = win_busy_q;
  assign win_done   = win_done_q;
  assign sample_cnt = sample_cnt_q;
  assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_vth_level_detector.sv
// Purpose: self-checking bench for vth_level_detector (two window configurations).
// Latency: expects det_* 2 cycles after each sample, counters 1 cycle after events.
// Backpressure: none exercised; the DUT always accepts.
module tb_vth_level_detector;

  logic        clk = 1'b0;
  logic        reset;
  logic        sample_valid;
  logic [15:0] sample_vth;
  logic [1:0]  ref_level;
  logic        cfg_we;
  logic [1:0]  cfg_sel;
  logic [15:0] cfg_data;
  logic        win_start;

  logic        d0_det_valid, d1_det_valid;
  logic [1:0]  d0_det_level, d1_det_level;
  logic [1:0]  d0_det_err, d1_det_err;
  logic        d0_win_busy, d1_win_busy;
  logic        d0_win_done, d1_win_done;
  logic [31:0] d0_sample_cnt, d0_err_cnt;
  logic [3:0]  d1_sample_cnt, d1_err_cnt;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  vth_level_detector #(.CNT_W(32), .WIN_LEN(8)) dut0 (
    .clk(clk), .reset(reset), .sample_valid(sample_valid), .sample_vth(sample_vth),
    .ref_level(ref_level), .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_data(cfg_data),
    .win_start(win_start), .det_valid(d0_det_valid), .det_level(d0_det_level),
    .det_err(d0_det_err), .win_busy(d0_win_busy), .win_done(d0_win_done),
    .sample_cnt(d0_sample_cnt), .err_cnt(d0_err_cnt)
  );

  vth_level_detector #(.CNT_W(4), .WIN_LEN(20)) dut1 (
    .clk(clk), .reset(reset), .sample_valid(sample_valid), .sample_vth(sample_vth),
    .ref_level(ref_level), .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_data(cfg_data),
    .win_start(win_start), .det_valid(d1_det_valid), .det_level(d1_det_level),
    .det_err(d1_det_err), .win_busy(d1_win_busy), .win_done(d1_win_done),
    .sample_cnt(d1_sample_cnt), .err_cnt(d1_err_cnt)
  );

  typedef struct {
    int vth;
    int rf;
    int lvl;
    int err_sym;
    int err_gray;
  } vec_t;

  typedef struct {
    int due;
    int lvl;
    int err;
  } exp_t;

  vec_t tbl[10];
  exp_t q[$];

  task automatic chk(input string nm, input longint act, input longint exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp_v, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle_inputs();
    sample_valid = 1'b0;
    sample_vth   = '0;
    ref_level    = '0;
    cfg_we       = 1'b0;
    cfg_sel      = '0;
    cfg_data     = '0;
    win_start    = 1'b0;
  endtask

  // Reference: level = thresholds met; error = symbol or Gray bit distance.
  function automatic int ref_err(input int lvl, input int rf);
`ifdef VTH_DET_GRAY_EN
    int ga, gb;
    ga = lvl ^ (lvl >> 1);
    gb = rf ^ (rf >> 1);
    return $countones(ga ^ gb);
`else
    return (lvl != rf) ? 1 : 0;
`endif
  endfunction

  function automatic int tbl_err(input vec_t v);
`ifdef VTH_DET_GRAY_EN
    return v.err_gray;
`else
    return v.err_sym;
`endif
  endfunction

  initial begin
    int tm[3];
    int cnt_all, e0, e1, lvl, er, s, d1s, d1e;
    logic [1:0] rl;

    // Defaults 1000/2000/3000: vth, ref, level, symbol err, Gray bit err.
    tbl[0] = '{999,   0, 0, 0, 0};
    tbl[1] = '{1000,  1, 1, 0, 0};
    tbl[2] = '{2500,  2, 2, 0, 0};
    tbl[3] = '{65535, 3, 3, 0, 0};
    tbl[4] = '{1500,  3, 1, 1, 2};
    tbl[5] = '{0,     0, 0, 0, 0};
    tbl[6] = '{1999,  2, 1, 1, 1};
    tbl[7] = '{2000,  0, 2, 1, 2};
    tbl[8] = '{2999,  3, 2, 1, 1};
    tbl[9] = '{3000,  0, 3, 1, 1};

    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    chk("rst_det_valid", d0_det_valid, 0);
    chk("rst_det_level", d0_det_level, 0);
    chk("rst_det_err", d0_det_err, 0);
    chk("rst_win_busy", d0_win_busy, 0);
    chk("rst_win_done", d0_win_done, 0);
    chk("rst_sample_cnt", d0_sample_cnt, 0);
    chk("rst_err_cnt", d0_err_cnt, 0);
    reset = 1'b0;
    tick();

    // Back-to-back table vectors; entry i-1 shows after the tick of iteration i.
    for (int i = 0; i <= 10; i++) begin
      if (i < 10) begin
        sample_valid = 1'b1;
        sample_vth   = 16'(tbl[i].vth);
        ref_level    = 2'(tbl[i].rf);
      end else begin
        sample_valid = 1'b0;
      end
      tick();
      if (i >= 1) begin
        chk($sformatf("tbl%0d_valid", i - 1), d0_det_valid, 1);
        chk($sformatf("tbl%0d_level", i - 1), d0_det_level, tbl[i - 1].lvl);
        chk($sformatf("tbl%0d_err", i - 1), d0_det_err, tbl_err(tbl[i - 1]));
        chk($sformatf("tbl%0d_level_d1", i - 1), d1_det_level, tbl[i - 1].lvl);
      end
    end
    tick();
    chk("tbl_valid_drop", d0_det_valid, 0);

    // Threshold write in the same cycle as a sample uses the old value.
    cfg_we = 1'b1; cfg_sel = 2'd1; cfg_data = 16'd1500;
    sample_valid = 1'b1; sample_vth = 16'd1600; ref_level = 2'd1;
    tick();
    cfg_we = 1'b0;
    sample_vth = 16'd1600; ref_level = 2'd2;
    tick();
    sample_valid = 1'b0;
    cfg_we = 1'b1; cfg_sel = 2'd3; cfg_data = 16'd0;
    chk("wr_same_cycle_level", d0_det_level, 1);
    chk("wr_same_cycle_err", d0_det_err, 0);
    tick();
    cfg_we = 1'b0;
    chk("wr_next_cycle_level", d0_det_level, 2);
    sample_valid = 1'b1; sample_vth = 16'd500; ref_level = 2'd0;
    tick();
    sample_valid = 1'b0;
    tick();
    chk("wr_sel3_ignored_level", d0_det_level, 0);

    // Reset in the middle of RUN aborts the window and restores T1.
    win_start = 1'b1;
    tick();
    win_start = 1'b0;
    sample_valid = 1'b1; sample_vth = 16'd2500; ref_level = 2'd0;
    tick();
    tick();
    sample_valid = 1'b0;
    chk("run_busy", d0_win_busy, 1);
    chk("run_sample_cnt", d0_sample_cnt, 2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_det_valid", d0_det_valid, 0);
    chk("midrst_busy", d0_win_busy, 0);
    chk("midrst_done", d0_win_done, 0);
    chk("midrst_sample_cnt", d0_sample_cnt, 0);
    chk("midrst_err_cnt", d0_err_cnt, 0);
    sample_valid = 1'b1; sample_vth = 16'd1600; ref_level = 2'd1;
    tick();
    sample_valid = 1'b0;
    tick();
    chk("midrst_t1_restored", d0_det_level, 1);
    tick();
    tick();
    chk("midrst_no_done", d0_win_done, 0);

    // Window of 8 with 3 weight-1 mismatches, then 2 mismatching extras.
    win_start = 1'b1;
    tick();
    win_start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      sample_valid = 1'b1;
      case (i)
        1:       begin sample_vth = 16'd500;  ref_level = 2'd1; end
        4:       begin sample_vth = 16'd2500; ref_level = 2'd1; end
        6, 8, 9: begin sample_vth = 16'd4000; ref_level = 2'd2; end
        default: begin sample_vth = 16'd2500; ref_level = 2'd2; end
      endcase
      tick();
      if (i == 8) chk("win8_done_early", d0_win_done, 0);
      if (i == 9) chk("win8_done_at_n3", d0_win_done, 1);
    end
    idle_inputs();
    tick();
    tick();
    tick();
    chk("win8_sample_cnt", d0_sample_cnt, 8);
    chk("win8_err_cnt", d0_err_cnt, 3);
    chk("win8_busy_off", d0_win_busy, 0);
    chk("win8_done_held", d0_win_done, 1);
    chk("win20_sample_cnt", d1_sample_cnt, 10);
    chk("win20_err_cnt", d1_err_cnt, 5);
    chk("win20_busy", d1_win_busy, 1);

    // Restart while dut1 is in RUN, then saturate the 4-bit counters.
    win_start = 1'b1;
    tick();
    win_start = 1'b0;
    chk("restart_sample_cnt", d1_sample_cnt, 0);
    chk("restart_done_clr", d0_win_done, 0);
    for (int i = 0; i < 20; i++) begin
      sample_valid = 1'b1; sample_vth = 16'd999; ref_level = 2'd1;
      tick();
      if (i == 16) chk("sat_sample_cnt_early", d1_sample_cnt, 15);
    end
    idle_inputs();
    repeat (4) tick();
    chk("sat_sample_cnt", d1_sample_cnt, 15);
    chk("sat_err_cnt", d1_err_cnt, 15);
    chk("sat_done", d1_win_done, 1);
    chk("sat_d0_sample_cnt", d0_sample_cnt, 8);
    chk("sat_d0_err_cnt", d0_err_cnt, 8);

    // Randomized run against the reference model (thresholds, writes, window).
    tm[0] = 1000; tm[1] = 2000; tm[2] = 3000;
    cnt_all = 0; e0 = 0; e1 = 0;
    q.delete();
    for (int k = 0; k < 90; k++) begin
      idle_inputs();
      if (k == 0) begin
        win_start = 1'b1;
      end else if (k < 80) begin
        sample_valid = ($urandom_range(3) != 0);
        sample_vth   = 16'($urandom);
        if ($urandom_range(3) == 0) sample_vth = 16'(tm[$urandom_range(2)]);
        rl           = 2'($urandom_range(3));
        ref_level    = rl;
        cfg_we       = ($urandom_range(5) == 0);
        cfg_sel      = 2'($urandom_range(3));
        cfg_data     = 16'($urandom);
        if (sample_valid) begin
          lvl = 0;
          for (int t = 0; t < 3; t++) if (int'(sample_vth) >= tm[t]) lvl++;
          er = ref_err(lvl, int'(rl));
          q.push_back('{cyc + 2, lvl, er});
          cnt_all++;
          if (cnt_all <= 8) e0 += er;
          if (cnt_all <= 20) e1 += er;
        end
        if (cfg_we && cfg_sel != 2'd3) tm[cfg_sel] = int'(cfg_data);
      end
      tick();
      if (q.size() > 0 && q[0].due == cyc) begin
        chk("rnd_valid", d0_det_valid, 1);
        chk("rnd_level", d0_det_level, q[0].lvl);
        chk("rnd_err", d0_det_err, q[0].err);
        void'(q.pop_front());
      end else begin
        chk("rnd_valid_idle", d0_det_valid, 0);
      end
    end
    idle_inputs();
    s   = (cnt_all < 20) ? cnt_all : 20;
    d1s = (s > 15) ? 15 : s;
    d1e = (e1 > 15) ? 15 : e1;
    chk("rnd_d0_sample_cnt", d0_sample_cnt, (cnt_all < 8) ? cnt_all : 8);
    chk("rnd_d0_err_cnt", d0_err_cnt, e0);
    chk("rnd_d0_done", d0_win_done, (cnt_all >= 8) ? 1 : 0);
    chk("rnd_d1_sample_cnt", d1_sample_cnt, d1s);
    chk("rnd_d1_err_cnt", d1_err_cnt, d1e);
    chk("rnd_d1_done", d1_win_done, (cnt_all >= 20) ? 1 : 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
